// File: rtl/dm_responder_if.sv
// Data-memory bus between the pipeline MEM stage and the responder.
// It also carries the read-only debug/display port.
interface dm_responder_if;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_rdata;

  // Pipeline / testbench side: drives the accesses and receives the read data.
  modport master (
    output dm_addr, dm_wen, dm_wdata, dbg_addr,
    input  dm_rdata, dbg_rdata
  );

  // Responder side.
  modport slave (
    input  dm_addr, dm_wen, dm_wdata, dbg_addr,
    output dm_rdata, dbg_rdata
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder with the following parts:
//   - a byte-writable RAM, read-first, with two read ports (pipeline and debug);
//   - an MMIO window holding a free-running timer with compare/interrupt and an LED register;
//   - a sticky bus-error flag for pipeline accesses that hit no mapped region.
// Read data is registered. dm_rdata and dbg_rdata are selected from registered sources.
module dm_responder #(
  parameter int          RAM_AW    = 8,
  parameter logic [15:0] MMIO_BASE = 16'hBFD0
) (
  input  logic            clk,
  input  logic            resetn,
  dm_responder_if.slave   bus,
  output logic [15:0]     led,
  output logic            irq,
  output logic            bus_err
);

  localparam logic [7:0] OFF_COUNT   = 8'h00;
  localparam logic [7:0] OFF_COMPARE = 8'h04;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_CTRL    = 8'h0C;
  localparam logic [7:0] OFF_LED     = 8'h10;

  typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_MMIO} sel_t;

  // Address decode. Bits between the RAM index and bit 16 are ignored, so RAM aliases.
  logic              dm_ram_hit, dm_mmio_hit, dm_unmapped;
  logic              dbg_ram_hit, dbg_mmio_hit;
  logic [RAM_AW-1:0] dm_idx, dbg_idx;
  logic [7:0]        dm_off;
  logic [31:0]       wmask;

  assign dm_ram_hit   = (bus.dm_addr[31:16] == 16'h0000);
  assign dm_mmio_hit  = (bus.dm_addr[31:16] == MMIO_BASE);
  assign dm_unmapped  = !dm_ram_hit && !dm_mmio_hit;
  assign dbg_ram_hit  = (bus.dbg_addr[31:16] == 16'h0000);
  assign dbg_mmio_hit = (bus.dbg_addr[31:16] == MMIO_BASE);
  assign dm_idx       = bus.dm_addr[RAM_AW+1:2];
  assign dbg_idx      = bus.dbg_addr[RAM_AW+1:2];
  assign dm_off       = bus.dm_addr[7:0];

  // Expand the byte enables into a bit mask.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{bus.dm_wen[gi]}};
    end
  endgenerate

  // Timer / LED state.
  logic [31:0] count_reg, count_next, compare_reg, compare_next, count_inc;
  logic        pend_reg, pend_next, en_reg, en_next, ie_reg, ie_next;
  logic [15:0] led_reg, led_next;
  logic        bus_err_reg, bus_err_next;

  // Read-data path registers.
  logic [31:0] ram_q_reg, dbg_ram_q_reg, mmio_q_reg, dbg_mmio_q_reg;
  sel_t        dm_sel_reg, dbg_sel_reg;

  // RAM storage. It is not reset. Both reads sample the old word, so a same-edge write does not bypass into the read.
  logic [31:0] mem [2**RAM_AW];
  logic        ram_we;
  assign ram_we = resetn && dm_ram_hit && (bus.dm_wen != 4'h0);

  // Register read of the current (pre-update) MMIO state for a given offset.
  function automatic logic [31:0] mmio_read(input logic [7:0] off);
    case (off)
      OFF_COUNT:   return count_reg;
      OFF_COMPARE: return compare_reg;
      OFF_STATUS:  return {31'd0, pend_reg};
      OFF_CTRL:    return {30'd0, ie_reg, en_reg};
      OFF_LED:     return {16'd0, led_reg};
      default:     return 32'd0;
    endcase
  endfunction

  // RAM: per-lane write and two registered read ports.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dm_wen[i]) mem[dm_idx][i*8 +: 8] <= bus.dm_wdata[i*8 +: 8];
      end
    end
    ram_q_reg     <= mem[dm_idx];
    dbg_ram_q_reg <= mem[dbg_idx];
  end

  // Capture the read source and the MMIO read values. Reset clears both read outputs to zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      dm_sel_reg     <= SEL_NONE;
      dbg_sel_reg    <= SEL_NONE;
      mmio_q_reg     <= 32'd0;
      dbg_mmio_q_reg <= 32'd0;
    end else begin
      dm_sel_reg     <= dm_ram_hit  ? SEL_RAM : (dm_mmio_hit  ? SEL_MMIO : SEL_NONE);
      dbg_sel_reg    <= dbg_ram_hit ? SEL_RAM : (dbg_mmio_hit ? SEL_MMIO : SEL_NONE);
      mmio_q_reg     <= mmio_read(dm_off);
      dbg_mmio_q_reg <= mmio_read(bus.dbg_addr[7:0]);
    end
  end

  // Next-state logic for the timer, control, LED and bus-error registers.
  always_comb begin
    count_inc    = en_reg ? count_reg + 32'd1 : count_reg;
    count_next   = count_inc;
    compare_next = compare_reg;
    en_next      = en_reg;
    ie_next      = ie_reg;
    led_next     = led_reg;
    if (dm_mmio_hit && bus.dm_wen != 4'h0) begin
      case (dm_off)
        OFF_COUNT:   count_next   = (bus.dm_wdata & wmask) | (count_inc & ~wmask);
        OFF_COMPARE: compare_next = (bus.dm_wdata & wmask) | (compare_reg & ~wmask);
        OFF_CTRL: begin
          if (bus.dm_wen[0]) begin
            en_next = bus.dm_wdata[0];
            ie_next = bus.dm_wdata[1];
          end
        end
        OFF_LED:     led_next = (bus.dm_wdata[15:0] & wmask[15:0]) | (led_reg & ~wmask[15:0]);
        default:     ;
      endcase
    end
    // A compare match takes priority over a simultaneous W1C.
    pend_next = (en_reg && count_reg == compare_reg) ||
                (pend_reg && !(dm_mmio_hit && dm_off == OFF_STATUS &&
                               bus.dm_wen[0] && bus.dm_wdata[0]));
    bus_err_next = bus_err_reg || dm_unmapped;
  end

  // Register update. While in reset the registers clear and all writes are ignored.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg   <= 32'd0;
      compare_reg <= 32'd0;
      pend_reg    <= 1'b0;
      en_reg      <= 1'b0;
      ie_reg      <= 1'b0;
      led_reg     <= 16'd0;
      bus_err_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      compare_reg <= compare_next;
      pend_reg    <= pend_next;
      en_reg      <= en_next;
      ie_reg      <= ie_next;
      led_reg     <= led_next;
      bus_err_reg <= bus_err_next;
    end
  end

  assign bus.dm_rdata  = (dm_sel_reg == SEL_RAM)   ? ram_q_reg :
                         (dm_sel_reg == SEL_MMIO)  ? mmio_q_reg : 32'd0;
  assign bus.dbg_rdata = (dbg_sel_reg == SEL_RAM)  ? dbg_ram_q_reg :
                         (dbg_sel_reg == SEL_MMIO) ? dbg_mmio_q_reg : 32'd0;
  assign led     = led_reg;
  assign irq     = pend_reg & ie_reg;
  assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder.
// Each expected dm_rdata is queued when its access is driven, then popped and compared one edge later.
module tb_dm_responder;
  localparam logic [15:0] MMIO_BASE = 16'hBFD0;

  logic clk = 1'b0;
  logic resetn;
  logic [15:0] led;
  logic irq, bus_err;

  dm_responder_if bus ();

  dm_responder #(.RAM_AW(8), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave),
    .led(led), .irq(irq), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  logic [31:0] ram_model [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One bus transaction. Inputs are driven just after an edge, and the result is compared just after the next edge.
  task automatic cycle(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                       input bit chk, input logic [31:0] exp, input string tag);
    sb_entry_t e;
    bus.dm_addr  = addr;
    bus.dm_wen   = wen;
    bus.dm_wdata = wdata;
    e.chk = chk; e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    if (e.chk) check(e.tag, bus.dm_rdata, e.exp);
    bus.dm_addr = 32'h0;
    bus.dm_wen  = 4'h0;
  endtask

  task automatic idle();
    cycle(32'h0, 4'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  // Update the byte-lane model for a RAM write.
  task automatic model_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    logic [31:0] w;
    w = ram_model[addr[9:2]];
    for (int i = 0; i < 4; i++) if (wen[i]) w[i*8 +: 8] = wdata[i*8 +: 8];
    ram_model[addr[9:2]] = w;
  endtask

  task automatic ram_wr(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata);
    model_write(addr, wen, wdata);
    cycle(addr, wen, wdata, 1'b0, 32'h0, "");
  endtask

  task automatic ram_rd(input logic [31:0] addr, input string tag);
    cycle(addr, 4'h0, 32'h0, 1'b1, ram_model[addr[9:2]], tag);
  endtask

  task automatic mmio_wr(input logic [7:0] off, input logic [3:0] wen, input logic [31:0] wdata);
    cycle({MMIO_BASE, 8'h00, off}, wen, wdata, 1'b0, 32'h0, "");
  endtask

  task automatic mmio_rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
    cycle({MMIO_BASE, 8'h00, off}, 4'h0, 32'h0, 1'b1, exp, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, old;
    logic [3:0]  w;

    resetn = 1'b0;
    bus.dm_addr = 32'h0; bus.dm_wen = 4'h0; bus.dm_wdata = 32'h0; bus.dbg_addr = 32'h0;
    for (int i = 0; i < 256; i++) ram_model[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset led", {16'h0, led}, 32'h0);
    check("reset irq", {31'h0, irq}, 32'h0);
    check("reset bus_err", {31'h0, bus_err}, 32'h0);
    check("reset dm_rdata", bus.dm_rdata, 32'h0);
    check("reset dbg_rdata", bus.dbg_rdata, 32'h0);
    resetn = 1'b1;

    // Byte lanes.
    ram_wr(32'h10, 4'hF, 32'h11223344);
    ram_wr(32'h10, 4'b0100, 32'hAA000000);
    cycle(32'h10, 4'h0, 32'h0, 1'b1, 32'h11003344, "ram byte lane");
    ram_rd(32'h0000_0410, "ram alias");
    check("alias bus_err", {31'h0, bus_err}, 32'h0);

    // Read-first on both ports.
    ram_wr(32'h20, 4'hF, 32'h0);
    bus.dbg_addr = 32'h20;
    model_write(32'h20, 4'hF, 32'hDEADBEEF);
    cycle(32'h20, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, "read-first dm");
    check("read-first dbg", bus.dbg_rdata, 32'h0);
    ram_rd(32'h20, "after read-first");
    check("dbg ram", bus.dbg_rdata, 32'hDEADBEEF);

    // Random byte-enable patterns.
    for (int k = 0; k < 6; k++) begin
      a = {22'h0, 8'($urandom_range(64, 200)), 2'b00};
      d = $urandom;
      w = 4'($urandom_range(1, 14));
      ram_wr(a, 4'hF, $urandom);
      ram_wr(a, w, d);
      ram_rd(a, $sformatf("ram rand %0d", k));
    end

    // Timer: compare match and interrupt.
    mmio_wr(8'h04, 4'hF, 32'd5);
    mmio_wr(8'h00, 4'hF, 32'd0);
    mmio_wr(8'h0C, 4'hF, 32'd3);
    for (int k = 0; k <= 5; k++) begin
      mmio_rd(8'h00, 32'(k), $sformatf("count %0d", k));
      check($sformatf("irq after count %0d", k), {31'h0, irq}, {31'h0, k == 5});
    end
    mmio_rd(8'h08, 32'd1, "status pend");
    mmio_wr(8'h08, 4'h1, 32'd1);
    check("irq after w1c", {31'h0, irq}, 32'h0);

    // Match and W1C on the same edge: the set takes priority.
    mmio_wr(8'h00, 4'hF, 32'd3);
    mmio_rd(8'h08, 32'd0, "status cleared");
    idle();
    mmio_wr(8'h08, 4'h1, 32'd1);
    check("irq set beats w1c", {31'h0, irq}, 32'h1);

    // Partial write concurrent with an increment.
    mmio_wr(8'h00, 4'hF, 32'h100);
    mmio_wr(8'h00, 4'h1, 32'h0000_00AA);
    mmio_rd(8'h00, 32'h1AA, "count partial write");
    mmio_wr(8'h04, 4'b0010, 32'h0000_0700);
    mmio_rd(8'h04, 32'h705, "compare byte lane");

    // Wrap.
    mmio_wr(8'h00, 4'hF, 32'hFFFF_FFFE);
    mmio_rd(8'h00, 32'hFFFF_FFFE, "wrap 0");
    mmio_rd(8'h00, 32'hFFFF_FFFF, "wrap 1");
    mmio_rd(8'h00, 32'h0, "wrap 2");
    mmio_rd(8'h00, 32'h1, "wrap 3");

    // CTRL readback, and gating of irq by ie.
    mmio_rd(8'h0C, 32'd3, "ctrl");
    mmio_wr(8'h0C, 4'hF, 32'd1);
    check("irq gated by ie", {31'h0, irq}, 32'h0);

    // LED register.
    mmio_wr(8'h10, 4'hF, 32'h1234_FFFF);
    check("led full", {16'h0, led}, 32'hFFFF);
    mmio_rd(8'h10, 32'h0000_FFFF, "led read");
    mmio_wr(8'h10, 4'b0010, 32'h0000_5500);
    check("led byte", {16'h0, led}, 32'h55FF);
    mmio_wr(8'h10, 4'b0010, 32'h0000_FF00);
    bus.dbg_addr = {MMIO_BASE, 16'h0010};
    idle();
    check("dbg led", bus.dbg_rdata, 32'h0000_FFFF);

    // Unused MMIO offset, and an unmapped debug read.
    mmio_wr(8'h40, 4'hF, 32'h1234_5678);
    mmio_rd(8'h40, 32'h0, "mmio unused");
    bus.dbg_addr = 32'h8000_0000;
    idle();
    check("dbg unmapped", bus.dbg_rdata, 32'h0);
    check("dbg no bus_err", {31'h0, bus_err}, 32'h0);

    // Reset while the timer is running. A RAM write attempted during reset must be ignored.
    mmio_wr(8'h00, 4'hF, 32'd100);
    resetn = 1'b0;
    cycle(32'h10, 4'hF, 32'hBADB_AD00, 1'b1, 32'h0, "rdata in reset");
    resetn = 1'b1;
    check("led after reset", {16'h0, led}, 32'h0);
    check("irq after reset", {31'h0, irq}, 32'h0);
    mmio_rd(8'h00, 32'h0, "count after reset");
    mmio_rd(8'h00, 32'h0, "count held");
    mmio_rd(8'h04, 32'h0, "compare after reset");
    mmio_rd(8'h08, 32'h0, "status after reset");
    mmio_rd(8'h0C, 32'h0, "ctrl after reset");
    mmio_rd(8'h10, 32'h0, "led reg after reset");
    ram_rd(32'h10, "ram kept over reset");

    // Unmapped pipeline accesses.
    check("bus_err before", {31'h0, bus_err}, 32'h0);
    cycle(32'h8000_0000, 4'h0, 32'h0, 1'b1, 32'h0, "unmapped read");
    check("bus_err set", {31'h0, bus_err}, 32'h1);
    cycle(32'h8000_0010, 4'hF, 32'h0, 1'b0, 32'h0, "");
    ram_rd(32'h10, "unmapped write dropped");
    idle();
    check("bus_err sticky", {31'h0, bus_err}, 32'h1);
    bus.dbg_addr = 32'h8000_0000;
    idle();
    check("dbg unmapped late", bus.dbg_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
